// File: rtl/draw_rect_overlay.sv
// Two-stage pixel pipeline that overlays a bordered, filled rectangle on the video stream.
// The rectangle position is latched at the start of vertical blanking so a frame never tears.
module draw_rect_overlay #(
    parameter int          RECT_WIDTH   = 64,
    parameter int          RECT_HEIGHT  = 48,
    parameter int          BORDER       = 2,
    parameter logic [11:0] FILL_COLOR   = 12'h0F0,
    parameter logic [11:0] BORDER_COLOR = 12'hFFF
) (
    input  logic        pclk,
    input  logic        reset,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam logic [12:0] RW = 13'(RECT_WIDTH);
    localparam logic [12:0] RH = 13'(RECT_HEIGHT);
    localparam logic [12:0] BW = 13'(BORDER);

    logic        vblnkPrev_q;
    logic [11:0] xposL_q, xposL_d;
    logic [11:0] yposL_q, yposL_d;

    logic [10:0] hcountS1_q, vcountS1_q;
    logic        hsyncS1_q, vsyncS1_q, hblnkS1_q, vblnkS1_q;
    logic [11:0] rgbS1_q;
    logic        inRectS1_q, inRectS1_d;
    logic        inInnerS1_q, inInnerS1_d;

    logic [10:0] hcountS2_q, vcountS2_q;
    logic        hsyncS2_q, vsyncS2_q, hblnkS2_q, vblnkS2_q;
    logic [11:0] rgbS2_q, rgbS2_d;

    logic [12:0] hExt, vExt, xExt, yExt;

    always_comb begin
        xposL_d = xposL_q;
        yposL_d = yposL_q;
        if (vblnk_in && !vblnkPrev_q) begin
            xposL_d = xpos;
            yposL_d = ypos;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            vblnkPrev_q <= 1'b0;
            xposL_q     <= '0;
            yposL_q     <= '0;
        end else begin
            vblnkPrev_q <= vblnk_in;
            xposL_q     <= xposL_d;
            yposL_q     <= yposL_d;
        end
    end

    // 13-bit compares keep position + size from wrapping past the 12-bit position range.
    assign hExt = {2'b00, hcount_in};
    assign vExt = {2'b00, vcount_in};
    assign xExt = {1'b0, xposL_q};
    assign yExt = {1'b0, yposL_q};

    always_comb begin
        inRectS1_d  = (hExt >= xExt) && (hExt < xExt + RW) &&
                      (vExt >= yExt) && (vExt < yExt + RH);
        inInnerS1_d = (hExt >= xExt + BW) && (hExt < xExt + RW - BW) &&
                      (vExt >= yExt + BW) && (vExt < yExt + RH - BW);
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            hcountS1_q  <= '0;
            vcountS1_q  <= '0;
            hsyncS1_q   <= 1'b0;
            vsyncS1_q   <= 1'b0;
            hblnkS1_q   <= 1'b0;
            vblnkS1_q   <= 1'b0;
            rgbS1_q     <= '0;
            inRectS1_q  <= 1'b0;
            inInnerS1_q <= 1'b0;
        end else begin
            hcountS1_q  <= hcount_in;
            vcountS1_q  <= vcount_in;
            hsyncS1_q   <= hsync_in;
            vsyncS1_q   <= vsync_in;
            hblnkS1_q   <= hblnk_in;
            vblnkS1_q   <= vblnk_in;
            rgbS1_q     <= rgb_in;
            inRectS1_q  <= inRectS1_d;
            inInnerS1_q <= inInnerS1_d;
        end
    end

    always_comb begin
        rgbS2_d = rgbS1_q;
        if (hblnkS1_q || vblnkS1_q) begin
            rgbS2_d = 12'h000;
        end else if (inInnerS1_q) begin
            rgbS2_d = FILL_COLOR;
        end else if (inRectS1_q) begin
            rgbS2_d = BORDER_COLOR;
        end
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            hcountS2_q <= '0;
            vcountS2_q <= '0;
            hsyncS2_q  <= 1'b0;
            vsyncS2_q  <= 1'b0;
            hblnkS2_q  <= 1'b0;
            vblnkS2_q  <= 1'b0;
            rgbS2_q    <= '0;
        end else begin
            hcountS2_q <= hcountS1_q;
            vcountS2_q <= vcountS1_q;
            hsyncS2_q  <= hsyncS1_q;
            vsyncS2_q  <= vsyncS1_q;
            hblnkS2_q  <= hblnkS1_q;
            vblnkS2_q  <= vblnkS1_q;
            rgbS2_q    <= rgbS2_d;
        end
    end

    assign hcount_out = hcountS2_q;
    assign vcount_out = vcountS2_q;
    assign hsync_out  = hsyncS2_q;
    assign vsync_out  = vsyncS2_q;
    assign hblnk_out  = hblnkS2_q;
    assign vblnk_out  = vblnkS2_q;
    assign rgb_out    = rgbS2_q;

endmodule

// File: tb/tb_draw_rect_overlay.sv
// Randomised bench for draw_rect_overlay: a frame-level reference model predicts every output
// two cycles later; a second instance built with BORDER=0 shares the same stimulus.
module tb_draw_rect_overlay;

    localparam int W = 64;
    localparam int H = 48;

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic        reset = 1'b1;
    logic [10:0] hcount_in = '0, vcount_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
    logic [11:0] rgb_in = '0, xpos = '0, ypos = '0;

    logic [10:0] hcount_out, vcount_out, b0Hcount, b0Vcount;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic        b0Hsync, b0Vsync, b0Hblnk, b0Vblnk;
    logic [11:0] rgb_out, b0Rgb;

    draw_rect_overlay dut (
        .pclk(pclk), .reset(reset),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .hsync_out(hsync_out), .vsync_out(vsync_out),
        .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
        .rgb_out(rgb_out)
    );

    draw_rect_overlay #(.BORDER(0)) dutNoBorder (
        .pclk(pclk), .reset(reset),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
        .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos),
        .hcount_out(b0Hcount), .vcount_out(b0Vcount),
        .hsync_out(b0Hsync), .vsync_out(b0Vsync),
        .hblnk_out(b0Hblnk), .vblnk_out(b0Vblnk),
        .rgb_out(b0Rgb)
    );

    typedef struct packed {
        logic [10:0] hc;
        logic [10:0] vc;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic [11:0] rgb0;
    } exp_t;

    logic [49:0] obs;
    assign obs = {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, b0Rgb};

    int   vectors = 0;
    int   miscompares = 0;
    exp_t pipe[$];
    exp_t expNow = '0;
    int   modelX = 0, modelY = 0;
    logic modelPrev = 1'b0;

    function automatic logic [11:0] colour(int h, int v, int x, int y, int b, logic blank, logic [11:0] bg);
        bit inRect, inInner;
        inRect  = h >= x && h < x + W && v >= y && v < y + H;
        inInner = h >= x + b && h < x + W - b && v >= y + b && v < y + H - b;
        if (blank)   return 12'h000;
        if (inInner) return 12'h0F0;
        if (inRect)  return 12'hFFF;
        return bg;
    endfunction

    // Advances one pixel clock; afterwards expNow holds what the outputs must show.
    task automatic tick();
        exp_t e;
        logic wasReset;
        e = '0;
        wasReset = reset;
        if (reset) begin
            modelX = 0;
            modelY = 0;
            modelPrev = 1'b0;
        end else begin
            e.hc   = hcount_in;
            e.vc   = vcount_in;
            e.hs   = hsync_in;
            e.vs   = vsync_in;
            e.hb   = hblnk_in;
            e.vb   = vblnk_in;
            e.rgb  = colour(int'(hcount_in), int'(vcount_in), modelX, modelY, 2, hblnk_in || vblnk_in, rgb_in);
            e.rgb0 = colour(int'(hcount_in), int'(vcount_in), modelX, modelY, 0, hblnk_in || vblnk_in, rgb_in);
            if (vblnk_in && !modelPrev) begin
                modelX = int'(xpos);
                modelY = int'(ypos);
            end
            modelPrev = vblnk_in;
        end
        pipe.push_back(e);
        if (pipe.size() > 4) void'(pipe.pop_front());
        @(posedge pclk);
        #1;
        if (wasReset || pipe.size() < 2) expNow = '0;
        else expNow = pipe[pipe.size() - 2];
    endtask

    task automatic setPix(int h, int v, logic [11:0] bg);
        hcount_in = 11'(h);
        vcount_in = 11'(v);
        hblnk_in  = (h >= 800);
        vblnk_in  = (v >= 600);
        hsync_in  = (h >= 840 && h < 968);
        vsync_in  = (v >= 601 && v < 605);
        rgb_in    = bg;
    endtask

    task automatic latchPos(int x, int y);
        xpos = 12'(x);
        ypos = 12'(y);
        setPix(0, 599, 12'h000); tick();
        setPix(0, 600, 12'h000); tick();
        setPix(0, 0, 12'h000);   tick();
    endtask

    function automatic logic [11:0] randBg();
        return 12'($urandom_range(12'h100, 12'h7FF));
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            hcount_in = 11'($urandom); vcount_in = 11'($urandom);
            hsync_in = 1'($urandom); vsync_in = 1'($urandom);
            hblnk_in = 1'($urandom); vblnk_in = 1'($urandom);
            rgb_in = 12'($urandom); xpos = 12'($urandom); ypos = 12'($urandom);
            tick();
            vectors++;
            if (obs !== 50'b0) begin
                miscompares++;
                $display("FAIL reset_outputs: got %h expected %h", obs, 50'b0);
            end
        end
        reset = 1'b0;
        setPix(10, 100, 12'h00F);
        tick();
        tick();
        vectors++;
        if (obs !== expNow) begin
            miscompares++;
            $display("FAIL reset_release_model: got %h expected %h", obs, expNow);
        end
        vectors++;
        if ({hcount_out, vcount_out, rgb_out} !== {11'd10, 11'd100, 12'h00F}) begin
            miscompares++;
            $display("FAIL reset_release_pixel: got h=%0d v=%0d rgb=%h expected h=10 v=100 rgb=00f",
                     hcount_out, vcount_out, rgb_out);
        end
    endtask

    task automatic test_latency();
        int lines[12] = '{48, 49, 50, 51, 97, 98, 598, 599, 600, 601, 602, 0};
        latchPos(100, 50);
        foreach (lines[li]) begin
            for (int h = 0; h < 1056; h++) begin
                setPix(h, lines[li], randBg());
                tick();
                vectors++;
                if (obs !== expNow) begin
                    miscompares++;
                    $display("FAIL latency_bus: got %h expected %h", obs, expNow);
                end
                if (hblnk_out || vblnk_out) begin
                    vectors++;
                    if (rgb_out !== 12'h000) begin
                        miscompares++;
                        $display("FAIL blank_black: got %h expected 000", rgb_out);
                    end
                end
            end
        end
    endtask

    task automatic test_geometry();
        int gh[8]   = '{99, 100, 101, 102, 163, 164, 120, 120};
        int gv[8]   = '{60, 60, 60, 60, 60, 60, 97, 98};
        int gexp[8] = '{-1, 'hFFF, 'hFFF, 'h0F0, 'hFFF, -1, 'hFFF, -1};
        logic [11:0] bg, want;
        latchPos(100, 50);
        for (int i = 0; i < 8; i++) begin
            bg = randBg();
            want = (gexp[i] < 0) ? bg : 12'(gexp[i]);
            setPix(gh[i], gv[i], bg);
            tick();
            tick();
            vectors++;
            if (rgb_out !== want || obs !== expNow) begin
                miscompares++;
                $display("FAIL geometry(%0d,%0d): got %h expected %h", gh[i], gv[i], rgb_out, want);
            end
        end
    endtask

    task automatic test_anti_tear();
        int ph[6]   = '{100, 150, 300, 300, 100, 320};
        int pexp[6] = '{'hFFF, 'h0F0, -1, 'hFFF, -1, 'h0F0};
        logic [11:0] bg, want;
        latchPos(100, 180);
        setPix(10, 200, 12'h000);
        xpos = 12'd300;
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) latchPos(300, 180);
            bg = randBg();
            want = (pexp[i] < 0) ? bg : 12'(pexp[i]);
            setPix(ph[i], 200, bg);
            tick();
            tick();
            vectors++;
            if (rgb_out !== want || obs !== expNow) begin
                miscompares++;
                $display("FAIL anti_tear(%0d,200) step %0d: got %h expected %h", ph[i], i, rgb_out, want);
            end
        end
    endtask

    task automatic test_clipping();
        int ch[8]   = '{780, 781, 782, 799, 0, 10, 779, 790};
        int cv[8]   = '{590, 590, 590, 599, 590, 599, 590, 579};
        int cexp[8] = '{'hFFF, 'hFFF, 'h0F0, 'h0F0, -1, -1, -1, -1};
        logic [11:0] bg, want;
        latchPos(780, 580);
        for (int i = 0; i < 8; i++) begin
            bg = randBg();
            want = (cexp[i] < 0) ? bg : 12'(cexp[i]);
            setPix(ch[i], cv[i], bg);
            tick();
            tick();
            vectors++;
            if (rgb_out !== want || obs !== expNow) begin
                miscompares++;
                $display("FAIL clip(%0d,%0d): got %h expected %h", ch[i], cv[i], rgb_out, want);
            end
        end
        for (int h = 0; h < 1056; h++) begin
            setPix(h, 590, randBg());
            tick();
            vectors++;
            if (obs !== expNow) begin
                miscompares++;
                $display("FAIL clip_line: got %h expected %h", obs, expNow);
            end
        end
        latchPos(4000, 580);
        for (int i = 0; i < 4; i++) begin
            bg = randBg();
            setPix(ch[i], cv[i], bg);
            tick();
            tick();
            vectors++;
            if (rgb_out !== bg || b0Rgb !== bg) begin
                miscompares++;
                $display("FAIL offscreen(%0d,%0d): got %h/%h expected %h", ch[i], cv[i], rgb_out, b0Rgb, bg);
            end
        end
    endtask

    task automatic test_border0();
        int bh[4] = '{0, 63, 64, 2};
        int bv[4] = '{0, 47, 0, 2};
        int mainExp[4] = '{'hFFF, 'hFFF, -1, 'h0F0};
        int zeroExp[4] = '{'h0F0, 'h0F0, -1, 'h0F0};
        logic [11:0] bg, wantMain, wantZero;
        reset = 1'b1;
        setPix(500, 300, 12'h000);
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bg = randBg();
            wantMain = (mainExp[i] < 0) ? bg : 12'(mainExp[i]);
            wantZero = (zeroExp[i] < 0) ? bg : 12'(zeroExp[i]);
            setPix(bh[i], bv[i], bg);
            tick();
            tick();
            vectors++;
            if ({rgb_out, b0Rgb} !== {wantMain, wantZero} || obs !== expNow) begin
                miscompares++;
                $display("FAIL border0(%0d,%0d): got %h/%h expected %h/%h",
                         bh[i], bv[i], rgb_out, b0Rgb, wantMain, wantZero);
            end
        end
    endtask

    task automatic test_back_to_back();
        int h, v, r;
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 999));
            reset = (r < 3);
            if ($urandom_range(0, 49) == 0) begin
                xpos = ($urandom_range(0, 9) == 0) ? 12'd4000 : 12'($urandom_range(0, 850));
                ypos = 12'($urandom_range(0, 650));
            end
            if ($urandom_range(0, 1) == 1) begin
                h = modelX + int'($urandom_range(0, 72)) - 4;
                v = modelY + int'($urandom_range(0, 56)) - 4;
            end else begin
                h = int'($urandom_range(0, 1055));
                v = int'($urandom_range(0, 627));
            end
            if (h < 0) h = 0;
            if (h > 1055) h = 1055;
            if (v < 0) v = 0;
            if (v > 627) v = 627;
            setPix(h, v, 12'($urandom));
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            tick();
            vectors++;
            if (obs !== expNow) begin
                miscompares++;
                $display("FAIL back_to_back: got %h expected %h", obs, expNow);
            end
            vectors++;
            if ({b0Hcount, b0Vcount, b0Hsync, b0Vsync, b0Hblnk, b0Vblnk} !==
                {expNow.hc, expNow.vc, expNow.hs, expNow.vs, expNow.hb, expNow.vb}) begin
                miscompares++;
                $display("FAIL border0_timing: got %h expected %h",
                         {b0Hcount, b0Vcount, b0Hsync, b0Vsync, b0Hblnk, b0Vblnk},
                         {expNow.hc, expNow.vc, expNow.hs, expNow.vs, expNow.hb, expNow.vb});
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_geometry();
        test_anti_tear();
        test_clipping();
        test_border0();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/draw_rect_overlay.md
Name: draw_rect_overlay

Overview:
Pipelined pixel stage directly downstream of the 800x600@60 video timing controller; consumes its hcount/vcount/hsync/vsync/hblnk/vblnk bus plus an incoming background colour. Overlays a filled rectangle with a solid border at a movable position. Re-times the whole timing bus so sync, blank and colour stay aligned at the output. Position is sampled once per frame to prevent tearing.

Parameters:
RECT_WIDTH, 64, rectangle width in pixels (1..800)
RECT_HEIGHT, 48, rectangle height in lines (1..600)
BORDER, 2, border thickness in pixels/lines (0 = no border; must be < half of min(width,height))
FILL_COLOR, 12'h0_F_0, interior RGB444 colour
BORDER_COLOR, 12'hF_F_F, border RGB444 colour

Ports:
pclk  input  1  pixel clock, 40 MHz
reset  input  1  synchronous, active-high reset
hcount_in  input  11  horizontal pixel counter from timing stage
vcount_in  input  11  vertical line counter from timing stage
hsync_in  input  1  horizontal sync
vsync_in  input  1  vertical sync
hblnk_in  input  1  horizontal blank
vblnk_in  input  1  vertical blank
rgb_in  input  12  background colour for the current pixel
xpos  input  12  requested rectangle left edge (pixels)
ypos  input  12  requested rectangle top edge (lines)
hcount_out  output  11  hcount_in delayed 2 cycles
vcount_out  output  11  vcount_in delayed 2 cycles
hsync_out  output  1  hsync_in delayed 2 cycles
vsync_out  output  1  vsync_in delayed 2 cycles
hblnk_out  output  1  hblnk_in delayed 2 cycles
vblnk_out  output  1  vblnk_in delayed 2 cycles
rgb_out  output  12  composed pixel colour, aligned with the *_out timing signals

Behaviour:
- Single clock domain (pclk); every register is reset synchronously by reset=1.
- Reset: all outputs 0; internal pipeline registers 0; latched position xpos_l = ypos_l = 0; vblnk history register = 0.
- Latency: exactly 2 pclk cycles from any input to the corresponding output, for timing signals and colour alike. Never stalls, no handshake.
- Position latch:
  - vblnk_prev <= vblnk_in each cycle.
  - On the cycle where vblnk_in=1 and vblnk_prev=0 (rising edge), xpos_l <= xpos and ypos_l <= ypos.
  - Otherwise xpos_l and ypos_l hold.
  - xpos/ypos changes mid-frame have no visible effect until the next vblank start.
  - After reset, the first frame draws at (0,0).
- Stage 1 (registered):
  - Copy the timing bus and rgb_in.
  - in_rect = (hcount_in >= xpos_l) && (hcount_in < xpos_l + RECT_WIDTH) && (vcount_in >= ypos_l) && (vcount_in < ypos_l + RECT_HEIGHT).
  - in_inner uses the same test shrunk by BORDER on all four sides.
  - All comparisons use 13-bit unsigned arithmetic, so xpos_l + RECT_WIDTH never wraps.
  - A rectangle partly off-screen is clipped; one fully off-screen (e.g. xpos >= 800) draws nothing.
- Stage 2 (registered):
  - Copy the stage-1 timing bus.
  - rgb_out priority:
    1. hblnk or vblnk (stage-1 copies) = 1 → 12'h000
    2. in_inner → FILL_COLOR
    3. in_rect → BORDER_COLOR
    4. else → stage-1 rgb
  - BORDER=0 → in_inner == in_rect, so no border pixels appear.
- Simultaneous events: a vblank rising edge coinciding with the last visible-line pixels cannot occur (vblank starts after line 599). The latch affects stage 1 only from the following cycle.
- Reset mid-frame: outputs 0 on the next edge. After release, the pipeline refills within 2 cycles; position reverts to (0,0) until the next vblank rising edge.

Test Plan:
- Reset held 5 cycles with random inputs → all outputs 0. After release with rgb_in=12'h00F constant, rgb_out=12'h00F at hcount_out=10, vcount_out=100 (outside the default rectangle at 0,0).
- Latency check: drive the real timing stage, xpos=100, ypos=50 latched → hsync_out and every timing output equals its input delayed exactly 2 cycles over a full frame. rgb_out=0 whenever hblnk_out or vblnk_out is 1.
- Geometry, with xpos=100, ypos=50 and defaults: (h=99,v=60) → bg; (100,60) → 12'hFFF; (101,60) → 12'hFFF; (102,60) → 12'h0F0; (163,60) → 12'hFFF; (164,60) → bg; (120,97) → 12'hFFF; (120,98) → bg.
- Anti-tearing: change xpos from 100 to 300 while vcount_in=200 → remainder of frame still draws at 100. Next frame, after vblnk rising edge, draws at 300.
- Clipping: xpos=780, ypos=580 → columns 780..799 drawn, no pixels at h>=800 or v>=600, no wrap to column 0. xpos=4000 → no rectangle pixels anywhere.
- BORDER=0 build, xpos=0, ypos=0 → pixel (0,0) = 12'h0F0; (63,47) = 12'h0F0; (64,0) = bg.
